// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation encoding and arbiter state type for alu_arbiter.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_op_t;
  typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first valid requester after last_i, searched cyclically.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int k);
    logic [IW:0] s;
    s = {1'b0, base} + (IW+1)'(k);
    return (s >= (IW+1)'(N)) ? IW'(s - (IW+1)'(N)) : s[IW-1:0];
  endfunction
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any_o && valid_i[wrap(last_i, k)]) begin
        any_o                    = 1'b1;
        grant_o[wrap(last_i, k)] = 1'b1;
        idx_o                    = wrap(last_i, k);
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU with a single registered result slot.
// Define ALU_ARB_PERF_EN to add per-requester saturating stall counters on stall_cnt_o.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*XLEN-1:0] req_a_i,
  input  logic [NUM_REQ*XLEN-1:0] req_b_i,
  input  logic [NUM_REQ*4-1:0]    req_op_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  input  logic [NUM_REQ-1:0]      rsp_ready_i,
  output logic [XLEN-1:0]         rsp_result_o,
  output logic [XLEN-1:0]         alu_a_o,
  output logic [XLEN-1:0]         alu_b_o,
  output logic [3:0]              alu_op_o,
`ifdef ALU_ARB_PERF_EN
  output logic [NUM_REQ*16-1:0]   stall_cnt_o,
`endif
  input  logic [XLEN-1:0]         alu_result_i
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  arb_state_t         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d, last_q, last_d, win_idx;
  logic [XLEN-1:0]    result_q, result_d;
  logic [NUM_REQ-1:0] pick_grant;
  logic               any_valid, accept, can_issue, issue;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .valid_i (req_valid_i),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .idx_o   (win_idx),
    .any_o   (any_valid)
  );

  // Freeing the slot and refilling it can happen in the same cycle, giving 1 op/cycle.
  always_comb begin
    accept    = state_q == BUSY && rsp_ready_i[owner_q];
    can_issue = state_q == IDLE || accept;
    issue     = can_issue && any_valid;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= IW'(NUM_REQ - 1);
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = issue ? BUSY : (accept ? IDLE : state_q);
    owner_d  = issue ? win_idx : owner_q;
    last_d   = issue ? win_idx : last_q;
    result_d = issue ? alu_result_i : result_q;
  end

  always_comb begin
    req_ready_o  = issue ? pick_grant : '0;
    alu_a_o      = issue ? req_a_i[win_idx*XLEN +: XLEN] : '0;
    alu_b_o      = issue ? req_b_i[win_idx*XLEN +: XLEN] : '0;
    alu_op_o     = issue ? req_op_i[win_idx*4 +: 4] : ALU_ADD;
    rsp_valid_o  = state_q == BUSY ? NUM_REQ'(1) << owner_q : '0;
    rsp_result_o = result_q;
  end

`ifdef ALU_ARB_PERF_EN
  logic [15:0] stall_q [NUM_REQ];
  logic [15:0] stall_d [NUM_REQ];
  always_comb begin
    stall_cnt_o = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      stall_d[r] = (req_valid_i[r] && !req_ready_o[r] && stall_q[r] != 16'hFFFF) ? stall_q[r] + 16'd1 : stall_q[r];
      stall_cnt_o[r*16 +: 16] = stall_q[r];
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    for (int r = 0; r < NUM_REQ; r++) stall_q[r] <= rst_i ? 16'd0 : stall_d[r];
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter; the bench also plays the shared ALU.
module tb_alu_arbiter;
  import alu_pkg::*;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  req_valid_i = '0;
  logic [1:0]  req_ready_o;
  logic [63:0] req_a_i = '0;
  logic [63:0] req_b_i = '0;
  logic [7:0]  req_op_i = '0;
  logic [1:0]  rsp_valid_o;
  logic [1:0]  rsp_ready_i = '0;
  logic [31:0] rsp_result_o, alu_a_o, alu_b_o, alu_result_i;
  logic [3:0]  alu_op_o;
`ifdef ALU_ARB_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  typedef struct packed {logic [1:0] owner; logic [31:0] res;} exp_t;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_arbiter #(.NUM_REQ(2), .XLEN(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_op_i     (req_op_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_op_o     (alu_op_o),
`ifdef ALU_ARB_PERF_EN
    .stall_cnt_o  (stall_cnt_o),
`endif
    .alu_result_i (alu_result_i)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    alu_result_i = '0;
    case (alu_op_o)
      ALU_ADD:  alu_result_i = alu_a_o + alu_b_o;
      ALU_SUB:  alu_result_i = alu_a_o - alu_b_o;
      ALU_SLL:  alu_result_i = alu_a_o << alu_b_o[4:0];
      ALU_SLT:  alu_result_i = {31'd0, $signed(alu_a_o) < $signed(alu_b_o)};
      ALU_SLTU: alu_result_i = {31'd0, alu_a_o < alu_b_o};
      ALU_XOR:  alu_result_i = alu_a_o ^ alu_b_o;
      ALU_SRL:  alu_result_i = alu_a_o >> alu_b_o[4:0];
      ALU_SRA:  alu_result_i = $signed(alu_a_o) >>> alu_b_o[4:0];
      ALU_OR:   alu_result_i = alu_a_o | alu_b_o;
      ALU_AND:  alu_result_i = alu_a_o & alu_b_o;
      default:  alu_result_i = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input alu_op_t op);
    req_a_i[r*32 +: 32] = a;
    req_b_i[r*32 +: 32] = b;
    req_op_i[r*4 +: 4]  = op;
  endtask

  task automatic expect_rsp(input logic [1:0] owner, input logic [31:0] res);
    sb.push_back('{owner: owner, res: res});
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && |(rsp_valid_o & rsp_ready_i)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_rsp", {30'd0, rsp_valid_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_owner", {30'd0, rsp_valid_o}, {30'd0, e.owner});
        chk("rsp_result", rsp_result_o, e.res);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    @(negedge clk_i);
    chk("rst_rsp_valid", {30'd0, rsp_valid_o}, 32'd0);
    chk("rst_rsp_result", rsp_result_o, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready_o}, 32'd0);
    chk("idle_alu_a", alu_a_o, 32'd0);
    chk("idle_alu_op", {28'd0, alu_op_o}, 32'd0);
    step();
    rst_i = 1'b0;
    // 1: single ADD
    set_req(0, 32'd5, 32'd3, ALU_ADD);
    req_valid_i = 2'b01;
    rsp_ready_i = 2'b11;
    @(negedge clk_i);
    chk("t1_ready", {30'd0, req_ready_o}, 32'd1);
    chk("t1_alu_a", alu_a_o, 32'd5);
    expect_rsp(2'b01, 32'd8);
    step();
    req_valid_i = 2'b00;
    @(negedge clk_i);
    chk("t1_rsp_valid", {30'd0, rsp_valid_o}, 32'd1);
    chk("t1_ready_off", {30'd0, req_ready_o}, 32'd0);
    step();
    @(negedge clk_i);
    chk("t1_idle", {30'd0, rsp_valid_o}, 32'd0);
    // 2: back-to-back alternating grants; last grant was 0 so requester 1 leads
    step();
    set_req(0, 32'd10, 32'd1, ALU_SUB);
    set_req(1, 32'd7, 32'd2, ALU_XOR);
    req_valid_i = 2'b11;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk("t2_ready", {30'd0, req_ready_o}, (c % 2 == 0) ? 32'd2 : 32'd1);
      if (c > 0) chk("t2_rsp_valid", {30'd0, rsp_valid_o}, (c % 2 == 0) ? 32'd1 : 32'd2);
      if (c % 2 == 0) expect_rsp(2'b10, 32'd5);
      else expect_rsp(2'b01, 32'd9);
      step();
    end
    req_valid_i = 2'b00;
    @(negedge clk_i);
    chk("t2_tail_valid", {30'd0, rsp_valid_o}, 32'd1);
    step();
    @(negedge clk_i);
    chk("t2_idle", {30'd0, rsp_valid_o}, 32'd0);
    // 3: SRA held by a stalled consumer, pending req0 waits for the accept cycle
    step();
    set_req(1, 32'h8000_0000, 32'd4, ALU_SRA);
    set_req(0, 32'd3, 32'd4, ALU_OR);
    req_valid_i = 2'b10;
    rsp_ready_i = 2'b01;
    @(negedge clk_i);
    chk("t3_ready", {30'd0, req_ready_o}, 32'd2);
    chk("t3_alu_a", alu_a_o, 32'h8000_0000);
    expect_rsp(2'b10, 32'hF800_0000);
    step();
    req_valid_i = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("t3_hold_ready", {30'd0, req_ready_o}, 32'd0);
      chk("t3_hold_valid", {30'd0, rsp_valid_o}, 32'd2);
      chk("t3_hold_result", rsp_result_o, 32'hF800_0000);
      step();
    end
    rsp_ready_i = 2'b11;
    @(negedge clk_i);
    chk("t3_accept_ready", {30'd0, req_ready_o}, 32'd1);
    chk("t3_accept_result", rsp_result_o, 32'hF800_0000);
    expect_rsp(2'b01, 32'd7);
    step();
    req_valid_i = 2'b00;
    @(negedge clk_i);
    chk("t3_next_result", rsp_result_o, 32'd7);
    step();
    // 4: non-owner ready is ignored
    set_req(0, 32'd9, 32'd1, ALU_SLL);
    set_req(1, 32'd5, 32'd9, ALU_SLT);
    req_valid_i = 2'b01;
    rsp_ready_i = 2'b10;
    @(negedge clk_i);
    chk("t4_ready", {30'd0, req_ready_o}, 32'd1);
    expect_rsp(2'b01, 32'd18);
    step();
    req_valid_i = 2'b10;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      chk("t4_no_grant", {30'd0, req_ready_o}, 32'd0);
      chk("t4_valid", {30'd0, rsp_valid_o}, 32'd1);
      chk("t4_result", rsp_result_o, 32'd18);
      step();
    end
    rsp_ready_i = 2'b01;
    @(negedge clk_i);
    chk("t4_accept_ready", {30'd0, req_ready_o}, 32'd2);
    expect_rsp(2'b10, 32'd1);
    step();
    req_valid_i = 2'b00;
    rsp_ready_i = 2'b11;
    @(negedge clk_i);
    chk("t4_slt_valid", {30'd0, rsp_valid_o}, 32'd2);
    step();
    // 5: async reset while BUSY; pointer returns so requester 0 wins again
    set_req(0, 32'd2, 32'd2, ALU_AND);
    req_valid_i = 2'b01;
    rsp_ready_i = 2'b00;
    @(negedge clk_i);
    chk("t5_ready", {30'd0, req_ready_o}, 32'd1);
    step();
    req_valid_i = 2'b00;
    @(negedge clk_i);
    chk("t5_busy", {30'd0, rsp_valid_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t5_async_valid", {30'd0, rsp_valid_o}, 32'd0);
    chk("t5_async_result", rsp_result_o, 32'd0);
    step();
    rst_i = 1'b0;
    set_req(0, 32'd20, 32'd6, ALU_SUB);
    set_req(1, 32'd1, 32'd1, ALU_ADD);
    req_valid_i = 2'b11;
    rsp_ready_i = 2'b11;
    @(negedge clk_i);
    chk("t5_first_grant", {30'd0, req_ready_o}, 32'd1);
    expect_rsp(2'b01, 32'd14);
    step();
    req_valid_i = 2'b10;
    @(negedge clk_i);
    chk("t5_second_grant", {30'd0, req_ready_o}, 32'd2);
    expect_rsp(2'b10, 32'd2);
    step();
    req_valid_i = 2'b00;
    step();
    @(negedge clk_i);
    chk("t5_idle", {30'd0, rsp_valid_o}, 32'd0);
`ifdef ALU_ARB_PERF_EN
    // 6: stall counters, then saturation
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    set_req(0, 32'd1, 32'd1, ALU_ADD);
    req_valid_i = 2'b01;
    rsp_ready_i = 2'b00;
    step();
    req_valid_i = 2'b10;
    repeat (5) step();
    req_valid_i = 2'b00;
    @(negedge clk_i);
    chk("t6_stall1", {16'd0, stall_cnt_o[31:16]}, 32'd5);
    chk("t6_stall0", {16'd0, stall_cnt_o[15:0]}, 32'd0);
    step();
    req_valid_i = 2'b10;
    repeat (70000) step();
    @(negedge clk_i);
    chk("t6_saturate", {16'd0, stall_cnt_o[31:16]}, 32'h0000_FFFF);
    req_valid_i = 2'b00;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
`endif
    repeat (3) step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
